// File: rtl/simple_dual_port_ram.sv
// rtl/simple_dual_port_ram.sv - one-write/one-read RAM with byte enables, read latency 1/2, auto-clear.
// Optional per-lane even parity with error injection when RAM_PARITY_EN is defined.
module simple_dual_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int rd_latency = 1,
  parameter int rdw_mode   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [addr_width-1:0]     waddr,
  input  logic [data_width/8-1:0]   wbe,
  input  logic [data_width-1:0]     data_in,
  input  logic                      re,
  input  logic [addr_width-1:0]     raddr,
  output logic [data_width-1:0]     data_out,
  output logic                      rvalid,
`ifdef RAM_PARITY_EN
  output logic                      parity_err,
  input  logic                      par_inject,
`endif
  output logic                      busy
);

  localparam int be_width = data_width / 8;
  localparam int depth    = 1 << addr_width;
`ifdef RAM_PARITY_EN
  localparam int pw = data_width + 1;
`else
  localparam int pw = data_width;
`endif

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state, state_next;
  logic [addr_width-1:0]   cnt;
  logic [data_width-1:0]   mem [depth];

  logic                    wr_en;
  logic [addr_width-1:0]   wr_addr;
  logic [be_width-1:0]     wr_be;
  logic [data_width-1:0]   wr_data;
  logic                    rd_accept;
  logic [data_width-1:0]   rd_word;
  logic [pw-1:0]           rd_bus;
  logic                    s_valid;
  logic [pw-1:0]           s_bus;
  logic [pw-1:0]           out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && cnt == {addr_width{1'b1}}) state_next = IDLE;
  end

  assign busy = (state == CLEAR);

  // The clear sequencer owns the write port while busy; user requests are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_be   = wbe;
    wr_data = data_in;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_be   = {be_width{1'b1}};
        wr_data = '0;
      end else begin
        wr_en = we;
      end
    end
  end

  assign rd_accept = !rst && (state == IDLE) && re;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < be_width; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[raddr];
    for (int i = 0; i < be_width; i++) begin
      if (rdw_mode == 1 && wr_en && wr_addr == raddr && wr_be[i])
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

`ifdef RAM_PARITY_EN
  logic [be_width-1:0] par_mem [depth];
  logic [be_width-1:0] wr_par;
  logic [be_width-1:0] rd_par;
  logic [be_width-1:0] calc_par;

  // Injection only applies to user writes so auto-clear always leaves consistent parity.
  always_comb begin
    for (int i = 0; i < be_width; i++)
      wr_par[i] = (^wr_data[8*i +: 8]) ^ (par_inject && state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < be_width; i++) begin
        if (wr_be[i]) par_mem[wr_addr][i] <= wr_par[i];
      end
    end
  end

  always_comb begin
    rd_par = par_mem[raddr];
    for (int i = 0; i < be_width; i++) begin
      if (rdw_mode == 1 && wr_en && wr_addr == raddr && wr_be[i]) rd_par[i] = wr_par[i];
      calc_par[i] = ^rd_word[8*i +: 8];
    end
  end

  assign rd_bus     = {|(calc_par ^ rd_par), rd_word};
  assign parity_err = out_q[pw-1];
`else
  assign rd_bus = rd_word;
`endif

  generate
    if (rd_latency == 2) begin : g_lat2
      always_ff @(posedge clk) begin
        if (rst) begin
          s_valid <= 1'b0;
          s_bus   <= '0;
        end else begin
          s_valid <= rd_accept;
          if (rd_accept) s_bus <= rd_bus;
        end
      end
    end else begin : g_lat1
      assign s_valid = rd_accept;
      assign s_bus   = rd_bus;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= s_valid;
      if (s_valid) out_q <= s_bus;
    end
  end

  assign data_out = out_q[data_width-1:0];

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// tb/tb_simple_dual_port_ram.sv - directed checks on an 8-bit lat1/old-word and a 16-bit lat2/merged instance.
module tb_simple_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [3:0]  waddr, raddr;
  logic [0:0]  wbe;
  logic [7:0]  din, dout;
  logic        rvalid, busy;
  logic        we2, re2;
  logic [3:0]  waddr2, raddr2;
  logic [1:0]  wbe2;
  logic [15:0] din2, dout2;
  logic        rvalid2, busy2;
`ifdef RAM_PARITY_EN
  logic        perr, pinj, perr2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simple_dual_port_ram #(.data_width(8), .addr_width(4), .rd_latency(1), .rdw_mode(0)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .data_in(din),
    .re(re), .raddr(raddr), .data_out(dout), .rvalid(rvalid),
`ifdef RAM_PARITY_EN
    .parity_err(perr), .par_inject(pinj),
`endif
    .busy(busy));

  simple_dual_port_ram #(.data_width(16), .addr_width(4), .rd_latency(2), .rdw_mode(1)) dut16 (
    .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wbe(wbe2), .data_in(din2),
    .re(re2), .raddr(raddr2), .data_out(dout2), .rvalid(rvalid2),
`ifdef RAM_PARITY_EN
    .parity_err(perr2), .par_inject(1'b0),
`endif
    .busy(busy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; din = d; wbe = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd8(input string tag, input logic [3:0] a, input logic [7:0] exp);
    re = 1'b1; raddr = a;
    step();
    re = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1);
    chk(tag, dout, exp);
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we2 = 1'b1; waddr2 = a; din2 = d; wbe2 = be;
    step();
    we2 = 1'b0;
  endtask

  task automatic rd16(input string tag, input logic [3:0] a, input logic [15:0] exp);
    re2 = 1'b1; raddr2 = a;
    step();
    re2 = 1'b0;
    chk({tag, "_early"}, rvalid2, 0);
    step();
    chk({tag, "_rvalid"}, rvalid2, 1);
    chk(tag, dout2, exp);
  endtask

  initial begin
    rst = 1'b1; we = 0; re = 0; waddr = 0; raddr = 0; wbe = 0; din = 0;
    we2 = 0; re2 = 0; waddr2 = 0; raddr2 = 0; wbe2 = 0; din2 = 0;
`ifdef RAM_PARITY_EN
    pinj = 0;
`endif
    step();
    step();
    chk("rst_busy", busy, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy16", busy2, 1);
    chk("rst_dout16", dout2, 0);

    // Auto-clear: busy for exactly 16 edges; a write attempted mid-clear must be dropped.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", busy, 1);
      if (i == 10) begin we = 1; waddr = 4'd2; din = 8'hFF; wbe = 1; end
      else we = 0;
      step();
    end
    we = 0;
    chk("clr_done", busy, 0);
    chk("clr_done16", busy2, 0);
    for (int i = 0; i < 16; i++) rd8("clr_rd", 4'(i), 8'h00);
    step();
    chk("idle_rvalid", rvalid, 0);

    // Latency 1 throughput and hold.
    wr8(4'd0, 8'hA5);
    wr8(4'd1, 8'h56);
    wr8(4'd2, 8'hB4);
    re = 1; raddr = 4'd0; step(); chk("b2b0", dout, 8'hA5); chk("b2b0_v", rvalid, 1);
    raddr = 4'd1;         step(); chk("b2b1", dout, 8'h56); chk("b2b1_v", rvalid, 1);
    raddr = 4'd2;         step(); chk("b2b2", dout, 8'hB4); chk("b2b2_v", rvalid, 1);
    re = 0;               step(); chk("hold_v", rvalid, 0); chk("hold", dout, 8'hB4);

    // Read-during-write, old-word mode; wbe=0 no-op; different addresses independent.
    wr8(4'd5, 8'h11);
    we = 1; waddr = 4'd5; din = 8'h22; wbe = 1; re = 1; raddr = 4'd5;
    step();
    we = 0; re = 0;
    chk("rdw_old", dout, 8'h11);
    rd8("rdw_after", 4'd5, 8'h22);
    we = 1; waddr = 4'd5; din = 8'h77; wbe = 0;
    step();
    we = 0;
    rd8("wbe0", 4'd5, 8'h22);
    we = 1; waddr = 4'd6; din = 8'h33; wbe = 1; re = 1; raddr = 4'd5;
    step();
    we = 0; re = 0;
    chk("indep_rd", dout, 8'h22);
    rd8("indep_wr", 4'd6, 8'h33);

    // 16-bit byte lanes, latency 2.
    wr16(4'd3, 16'hA5A5, 2'b11);
    wr16(4'd3, 16'h1234, 2'b01);
    rd16("be16", 4'd3, 16'hA534);
    wr16(4'd0, 16'h00A5, 2'b11);
    wr16(4'd1, 16'h0056, 2'b11);
    wr16(4'd2, 16'h00B4, 2'b11);
    re2 = 1; raddr2 = 4'd0; step(); chk("l2_0v", rvalid2, 0);
    raddr2 = 4'd1;          step(); chk("l2_1v", rvalid2, 1); chk("l2_1", dout2, 16'h00A5);
    raddr2 = 4'd2;          step(); chk("l2_2v", rvalid2, 1); chk("l2_2", dout2, 16'h0056);
    re2 = 0;                step(); chk("l2_3v", rvalid2, 1); chk("l2_3", dout2, 16'h00B4);
    step(); chk("l2_hold_v", rvalid2, 0); chk("l2_hold", dout2, 16'h00B4);

    // Read-during-write, merged mode.
    wr16(4'd5, 16'h1111, 2'b11);
    we2 = 1; waddr2 = 4'd5; din2 = 16'h2222; wbe2 = 2'b01; re2 = 1; raddr2 = 4'd5;
    step();
    we2 = 0; re2 = 0;
    chk("rdw_new_early", rvalid2, 0);
    step();
    chk("rdw_new_v", rvalid2, 1);
    chk("rdw_new", dout2, 16'h1122);
    rd16("rdw_new_after", 4'd5, 16'h1122);

`ifdef RAM_PARITY_EN
    we = 1; waddr = 4'd9; din = 8'h5A; wbe = 1; pinj = 1;
    step();
    we = 0; pinj = 0;
    re = 1; raddr = 4'd9; step(); re = 0;
    chk("par_inj_v", rvalid, 1); chk("par_inj_err", perr, 1); chk("par_inj_d", dout, 8'h5A);
    wr8(4'd9, 8'h5A);
    re = 1; raddr = 4'd9; step(); re = 0;
    chk("par_ok_v", rvalid, 1); chk("par_ok_err", perr, 0);
`endif

    // In-flight read dropped by reset, then reset again at clear cycle 7.
    re2 = 1; raddr2 = 4'd3;
    step();
    re2 = 0; rst = 1;
    step();
    chk("flush_v0", rvalid2, 0);
    chk("flush_busy", busy, 1);
    rst = 0;
    step();
    chk("flush_v1", rvalid2, 0);
    for (int i = 0; i < 6; i++) step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      chk("reclr_busy", busy, 1);
      chk("reclr_busy16", busy2, 1);
      step();
    end
    chk("reclr_done", busy, 0);
    chk("reclr_done16", busy2, 0);
    rd8("reclr_a0", 4'd0, 8'h00);
    rd8("reclr_a5", 4'd5, 8'h00);
    rd16("reclr16_a3", 4'd3, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
